// File: rtl/rv_pkg.sv
// Shared RV32I decode encodings: opcodes, exe_fun codes, select encodings,
// the decoded-bundle struct and small decode helpers.
package rv_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef enum logic [4:0] {
        ALU_X      = 5'd0,  ALU_ADD   = 5'd1,  ALU_SUB   = 5'd2,  ALU_AND   = 5'd3,
        ALU_OR     = 5'd4,  ALU_XOR   = 5'd5,  ALU_SLL   = 5'd6,  ALU_SRL   = 5'd7,
        ALU_SRA    = 5'd8,  ALU_SLT   = 5'd9,  ALU_SLTU  = 5'd10, BR_BEQ    = 5'd11,
        BR_BNE     = 5'd12, BR_BLT    = 5'd13, BR_BGE    = 5'd14, BR_BLTU   = 5'd15,
        BR_BGEU    = 5'd16, ALU_JALR  = 5'd17, ALU_MUL   = 5'd18, ALU_MULH  = 5'd19,
        ALU_MULHSU = 5'd20, ALU_MULHU = 5'd21, ALU_DIV   = 5'd22, ALU_DIVU  = 5'd23,
        ALU_REM    = 5'd24, ALU_REMU  = 5'd25
    } exe_fun_e;

    localparam logic [1:0] OP1_X   = 2'd0;
    localparam logic [1:0] OP1_RS1 = 2'd1;
    localparam logic [1:0] OP1_PC  = 2'd2;
    localparam logic [1:0] OP1_IMZ = 2'd3;

    localparam logic [2:0] OP2_X   = 3'd0;
    localparam logic [2:0] OP2_RS2 = 3'd1;
    localparam logic [2:0] OP2_IMI = 3'd2;
    localparam logic [2:0] OP2_IMS = 3'd3;
    localparam logic [2:0] OP2_IMJ = 3'd4;
    localparam logic [2:0] OP2_IMU = 3'd5;

    localparam logic [1:0] MEN_X = 2'd0;
    localparam logic [1:0] MEN_S = 2'd1;
    localparam logic [1:0] REN_X = 2'd0;
    localparam logic [1:0] REN_S = 2'd1;

    localparam logic [2:0] WB_X   = 3'd0;
    localparam logic [2:0] WB_ALU = 3'd1;
    localparam logic [2:0] WB_MEM = 3'd2;
    localparam logic [2:0] WB_PC  = 3'd3;
    localparam logic [2:0] WB_CSR = 3'd4;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } stage_state_e;

    typedef struct packed {
        exe_fun_e    exe_fun;
        logic [1:0]  op1_sel;
        logic [2:0]  op2_sel;
        logic [1:0]  mem_wen;
        logic [1:0]  rf_wen;
        logic [2:0]  wb_sel;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        illegal;
    } dec_bundle_t;

    function automatic dec_bundle_t set_ctrl(input dec_bundle_t b, input exe_fun_e fun,
                                             input logic [1:0] op1, input logic [2:0] op2,
                                             input logic [1:0] men, input logic [1:0] ren,
                                             input logic [2:0] wb, input logic [31:0] imm);
        dec_bundle_t r;
        r         = b;
        r.exe_fun = fun;
        r.op1_sel = op1;
        r.op2_sel = op2;
        r.mem_wen = men;
        r.rf_wen  = ren;
        r.wb_sel  = wb;
        r.imm     = imm;
        r.illegal = 1'b0;
        return r;
    endfunction

    // alt selects SUB/SRA over ADD/SRL
    function automatic exe_fun_e alu_fun(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_X;
        endcase
    endfunction

    function automatic exe_fun_e br_fun(input logic [2:0] f3);
        case (f3)
            3'b000:  return BR_BEQ;
            3'b001:  return BR_BNE;
            3'b100:  return BR_BLT;
            3'b101:  return BR_BGE;
            3'b110:  return BR_BLTU;
            3'b111:  return BR_BGEU;
            default: return ALU_X;
        endcase
    endfunction

    function automatic exe_fun_e mul_fun(input logic [2:0] f3);
        case (f3)
            3'b000:  return ALU_MUL;
            3'b001:  return ALU_MULH;
            3'b010:  return ALU_MULHSU;
            3'b011:  return ALU_MULHU;
            3'b100:  return ALU_DIV;
            3'b101:  return ALU_DIVU;
            3'b110:  return ALU_REM;
            3'b111:  return ALU_REMU;
            default: return ALU_X;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_core.sv
// Combinational RV32I decoder producing the control bundle and illegal flag.
// Multiply/divide decode is compiled in with RV_M_EXT_EN.
module decode_core
    import rv_pkg::*;
(
    input  logic [31:0]                   inst,
    output logic [$bits(dec_bundle_t)-1:0] bundle
);

    logic [6:0]  opcode_s;
    logic [2:0]  funct3_s;
    logic [6:0]  funct7_s;
    logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    dec_bundle_t d_s;

    assign opcode_s = inst[6:0];
    assign funct3_s = inst[14:12];
    assign funct7_s = inst[31:25];
    assign imm_i_s  = {{20{inst[31]}}, inst[31:20]};
    assign imm_s_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
    assign imm_b_s  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
    assign imm_u_s  = {inst[31:12], 12'h000};
    assign imm_j_s  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

    // Decode table; everything starts illegal with all controls cleared
    always_comb begin
        d_s         = '0;
        d_s.illegal = 1'b1;
        d_s.rs1     = inst[19:15];
        d_s.rs2     = inst[24:20];
        case (opcode_s)
            OPC_LUI:   d_s = set_ctrl(d_s, ALU_ADD, OP1_X, OP2_IMU, MEN_X, REN_S, WB_ALU, imm_u_s);
            OPC_AUIPC: d_s = set_ctrl(d_s, ALU_ADD, OP1_PC, OP2_IMU, MEN_X, REN_S, WB_ALU, imm_u_s);
            OPC_JAL:   d_s = set_ctrl(d_s, ALU_ADD, OP1_PC, OP2_IMJ, MEN_X, REN_S, WB_PC, imm_j_s);
            OPC_JALR: begin
                if (funct3_s == 3'b000) begin
                    d_s = set_ctrl(d_s, ALU_JALR, OP1_RS1, OP2_IMI, MEN_X, REN_S, WB_PC, imm_i_s);
                end else begin
                    d_s.illegal = 1'b1;
                end
            end
            OPC_BRANCH: begin
                if (funct3_s[2:1] != 2'b01) begin
                    d_s = set_ctrl(d_s, br_fun(funct3_s), OP1_RS1, OP2_RS2, MEN_X, REN_X, WB_X, imm_b_s);
                end else begin
                    d_s.illegal = 1'b1;
                end
            end
            OPC_LOAD: begin
                if (funct3_s != 3'b011 && funct3_s != 3'b110 && funct3_s != 3'b111) begin
                    d_s = set_ctrl(d_s, ALU_ADD, OP1_RS1, OP2_IMI, MEN_X, REN_S, WB_MEM, imm_i_s);
                end else begin
                    d_s.illegal = 1'b1;
                end
            end
            OPC_STORE: begin
                if (!funct3_s[2] && funct3_s[1:0] != 2'b11) begin
                    d_s = set_ctrl(d_s, ALU_ADD, OP1_RS1, OP2_IMS, MEN_S, REN_X, WB_X, imm_s_s);
                end else begin
                    d_s.illegal = 1'b1;
                end
            end
            OPC_OPIMM: begin
                // Shift immediates reuse inst[31:25] as a funct7 that must be exact
                if ((funct3_s == 3'b001 && funct7_s != 7'b0000000) ||
                    (funct3_s == 3'b101 && funct7_s != 7'b0000000 && funct7_s != 7'b0100000)) begin
                    d_s.illegal = 1'b1;
                end else begin
                    d_s = set_ctrl(d_s, alu_fun(funct3_s, (funct3_s == 3'b101) && funct7_s[5]),
                                   OP1_RS1, OP2_IMI, MEN_X, REN_S, WB_ALU, imm_i_s);
                end
            end
            OPC_OP: begin
                if (funct7_s == 7'b0000000 ||
                    (funct7_s == 7'b0100000 && (funct3_s == 3'b000 || funct3_s == 3'b101))) begin
                    d_s = set_ctrl(d_s, alu_fun(funct3_s, funct7_s[5]),
                                   OP1_RS1, OP2_RS2, MEN_X, REN_S, WB_ALU, 32'h0000_0000);
`ifdef RV_M_EXT_EN
                end else if (funct7_s == 7'b0000001) begin
                    d_s = set_ctrl(d_s, mul_fun(funct3_s),
                                   OP1_RS1, OP2_RS2, MEN_X, REN_S, WB_ALU, 32'h0000_0000);
`endif
                end else begin
                    d_s.illegal = 1'b1;
                end
            end
            default: d_s.illegal = 1'b1;
        endcase
        if (d_s.rf_wen != REN_X) begin
            d_s.rd = inst[11:7];
        end else begin
            d_s.rd = 5'd0;
        end
    end

    assign bundle = d_s;

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: combinational decode feeding a 2-entry skid buffer with
// valid/ready on both sides. RV_M_EXT_EN enables multiply/divide decode.
module decode_stage
    import rv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      out_exe_fun,
    output logic [1:0]      out_op1_sel,
    output logic [2:0]      out_op2_sel,
    output logic [1:0]      out_mem_wen,
    output logic [1:0]      out_rf_wen,
    output logic [2:0]      out_wb_sel,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_illegal
);

    stage_state_e    state_r, state_next_s;
    dec_bundle_t     dec_s, head_r, skid_r;
    logic [XLEN-1:0] head_pc_r, skid_pc_r;
    logic            in_ready_r, out_valid_r;
    logic            accept_s, emit_s;
    logic            load_head_s, load_skid_s, head_from_skid_s;

    decode_core u_core (
        .inst   (in_inst),
        .bundle (dec_s)
    );

    assign accept_s = in_valid && in_ready_r;
    assign emit_s   = out_valid_r && out_ready;

    // Next-state and buffer-steering logic; head always holds the oldest entry
    always_comb begin
        state_next_s     = state_r;
        load_head_s      = 1'b0;
        load_skid_s      = 1'b0;
        head_from_skid_s = 1'b0;
        case (state_r)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_next_s = ST_ONE;
                    load_head_s  = 1'b1;
                end else begin
                    state_next_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && emit_s) begin
                    state_next_s = ST_ONE;
                    load_head_s  = 1'b1;
                end else if (accept_s) begin
                    state_next_s = ST_FULL;
                    load_skid_s  = 1'b1;
                end else if (emit_s) begin
                    state_next_s = ST_EMPTY;
                end else begin
                    state_next_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (emit_s) begin
                    state_next_s     = ST_ONE;
                    head_from_skid_s = 1'b1;
                end else begin
                    state_next_s = ST_FULL;
                end
            end
            default: state_next_s = ST_EMPTY;
        endcase
        if (flush) begin
            state_next_s     = ST_EMPTY;
            load_head_s      = 1'b0;
            load_skid_s      = 1'b0;
            head_from_skid_s = 1'b0;
        end else begin
            state_next_s = state_next_s;
        end
    end

    // State and handshake flags, registered from the next state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_EMPTY;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            in_ready_r  <= (state_next_s != ST_FULL);
            out_valid_r <= (state_next_s != ST_EMPTY);
        end
    end

    // Buffer entries; move only on accept or when the skid refills the head
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_r    <= '0;
            head_pc_r <= '0;
            skid_r    <= '0;
            skid_pc_r <= '0;
        end else begin
            if (load_head_s) begin
                head_r    <= dec_s;
                head_pc_r <= in_pc;
            end else if (head_from_skid_s) begin
                head_r    <= skid_r;
                head_pc_r <= skid_pc_r;
            end
            if (load_skid_s) begin
                skid_r    <= dec_s;
                skid_pc_r <= in_pc;
            end
        end
    end

    assign in_ready    = in_ready_r;
    assign out_valid   = out_valid_r;
    assign out_pc      = head_pc_r;
    assign out_exe_fun = head_r.exe_fun;
    assign out_op1_sel = head_r.op1_sel;
    assign out_op2_sel = head_r.op2_sel;
    assign out_mem_wen = head_r.mem_wen;
    assign out_rf_wen  = head_r.rf_wen;
    assign out_wb_sel  = head_r.wb_sel;
    assign out_rs1     = head_r.rs1;
    assign out_rs2     = head_r.rs2;
    assign out_rd      = head_r.rd;
    assign out_imm     = XLEN'($signed(head_r.imm));
    assign out_illegal = head_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Directed self-checking bench for decode_stage: decode fields, immediates,
// back-pressure, flush, asynchronous reset and optional M-extension decode.
module tb_decode_stage;
    import rv_pkg::*;

    localparam int XLEN = 32;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [31:0]     in_inst = 32'h0;
    logic [XLEN-1:0] in_pc = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] out_pc;
    logic [4:0]      out_exe_fun;
    logic [1:0]      out_op1_sel;
    logic [2:0]      out_op2_sel;
    logic [1:0]      out_mem_wen;
    logic [1:0]      out_rf_wen;
    logic [2:0]      out_wb_sel;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_illegal;

    int n_checks = 0;
    int n_fail   = 0;

    decode_stage #(.XLEN(XLEN)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_exe_fun(out_exe_fun), .out_op1_sel(out_op1_sel), .out_op2_sel(out_op2_sel),
        .out_mem_wen(out_mem_wen), .out_rf_wen(out_rf_wen), .out_wb_sel(out_wb_sel),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_imm(out_imm), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [31:0] inst, input logic [31:0] pc);
        in_valid = v;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got=%b exp=1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (out_exe_fun !== 5'd0) begin n_fail++; $display("FAIL rst_exe_fun got=%0d exp=0", out_exe_fun); end
        n_checks++; if (out_illegal !== 1'b0) begin n_fail++; $display("FAIL rst_illegal got=%b exp=0", out_illegal); end
        n_checks++; if (out_pc !== 32'h0 || out_imm !== 32'h0 || out_rd !== 5'd0 || out_rf_wen !== 2'd0)
            begin n_fail++; $display("FAIL rst_data pc=%h imm=%h rd=%0d rf_wen=%0d exp all 0", out_pc, out_imm, out_rd, out_rf_wen); end
        rst = 1'b0;
    endtask

    task automatic test_addi();
        out_ready = 1'b1;
        drive(1'b1, 32'h0050_0093, 32'h0000_0100);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL addi_valid got=%b exp=1", out_valid); end
        n_checks++; if (out_exe_fun !== ALU_ADD) begin n_fail++; $display("FAIL addi_fun got=%0d exp=%0d", out_exe_fun, ALU_ADD); end
        n_checks++; if (out_op1_sel !== OP1_RS1 || out_op2_sel !== OP2_IMI)
            begin n_fail++; $display("FAIL addi_sel op1=%0d op2=%0d exp 1/2", out_op1_sel, out_op2_sel); end
        n_checks++; if (out_imm !== 32'd5) begin n_fail++; $display("FAIL addi_imm got=%h exp=5", out_imm); end
        n_checks++; if (out_rd !== 5'd1 || out_rf_wen !== REN_S || out_wb_sel !== WB_ALU)
            begin n_fail++; $display("FAIL addi_wb rd=%0d rf_wen=%0d wb=%0d exp 1/1/1", out_rd, out_rf_wen, out_wb_sel); end
        n_checks++; if (out_pc !== 32'h100) begin n_fail++; $display("FAIL addi_pc got=%h exp=100", out_pc); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL addi_drained got=%b exp=0", out_valid); end
    endtask

    task automatic test_sub_illegal();
        out_ready = 1'b1;
        drive(1'b1, 32'h4020_81B3, 32'h0000_0104);
        @(negedge clk);
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0108);
        n_checks++; if (out_exe_fun !== ALU_SUB || out_illegal !== 1'b0)
            begin n_fail++; $display("FAIL sub_fun got=%0d ill=%b exp=%0d/0", out_exe_fun, out_illegal, ALU_SUB); end
        n_checks++; if (out_rs1 !== 5'd1 || out_rs2 !== 5'd2 || out_rd !== 5'd3)
            begin n_fail++; $display("FAIL sub_regs rs1=%0d rs2=%0d rd=%0d exp 1/2/3", out_rs1, out_rs2, out_rd); end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h108)
            begin n_fail++; $display("FAIL ill_order valid=%b pc=%h exp 1/108", out_valid, out_pc); end
        n_checks++; if (out_illegal !== 1'b1 || out_rf_wen !== 2'd0 || out_rd !== 5'd0 || out_exe_fun !== 5'd0)
            begin n_fail++; $display("FAIL ill_fields ill=%b rf_wen=%0d rd=%0d fun=%0d exp 1/0/0/0", out_illegal, out_rf_wen, out_rd, out_exe_fun); end
        n_checks++; if (out_mem_wen !== 2'd0 || out_wb_sel !== 3'd0 || out_op1_sel !== 2'd0 || out_op2_sel !== 3'd0)
            begin n_fail++; $display("FAIL ill_sels men=%0d wb=%0d op1=%0d op2=%0d exp 0", out_mem_wen, out_wb_sel, out_op1_sel, out_op2_sel); end
        @(negedge clk);
    endtask

    task automatic test_imm_formats();
        logic [31:0] v_inst [7];
        logic [4:0]  v_fun  [7];
        logic [31:0] v_imm  [7];
        logic [4:0]  v_rd   [7];
        logic [2:0]  v_op2  [7];
        logic        v_ill  [7];
        v_inst[0] = 32'hFE20_AE23; v_fun[0] = ALU_ADD; v_imm[0] = 32'hFFFF_FFFC; v_rd[0] = 5'd0; v_op2[0] = OP2_IMS; v_ill[0] = 1'b0;
        v_inst[1] = 32'hFE20_8CE3; v_fun[1] = BR_BEQ;  v_imm[1] = 32'hFFFF_FFF8; v_rd[1] = 5'd0; v_op2[1] = OP2_RS2; v_ill[1] = 1'b0;
        v_inst[2] = 32'h1234_52B7; v_fun[2] = ALU_ADD; v_imm[2] = 32'h1234_5000; v_rd[2] = 5'd5; v_op2[2] = OP2_IMU; v_ill[2] = 1'b0;
        v_inst[3] = 32'h8000_02B7; v_fun[3] = ALU_ADD; v_imm[3] = 32'h8000_0000; v_rd[3] = 5'd5; v_op2[3] = OP2_IMU; v_ill[3] = 1'b0;
        v_inst[4] = 32'h0010_00EF; v_fun[4] = ALU_ADD; v_imm[4] = 32'h0000_0800; v_rd[4] = 5'd1; v_op2[4] = OP2_IMJ; v_ill[4] = 1'b0;
        v_inst[5] = 32'h4030_D093; v_fun[5] = ALU_SRA; v_imm[5] = 32'h0000_0403; v_rd[5] = 5'd1; v_op2[5] = OP2_IMI; v_ill[5] = 1'b0;
        v_inst[6] = 32'h4030_9093; v_fun[6] = ALU_X;   v_imm[6] = 32'h0000_0000; v_rd[6] = 5'd0; v_op2[6] = OP2_X;   v_ill[6] = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, v_inst[i], 32'h400 + 32'(i * 4));
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || out_exe_fun !== v_fun[i] || out_imm !== v_imm[i] || out_rd !== v_rd[i] ||
                out_op2_sel !== v_op2[i] || out_illegal !== v_ill[i] || out_pc !== 32'h400 + 32'(i * 4)) begin
                n_fail++;
                $display("FAIL imm_vec%0d got v=%b fun=%0d imm=%h rd=%0d op2=%0d ill=%b pc=%h exp fun=%0d imm=%h rd=%0d op2=%0d ill=%b",
                         i, out_valid, out_exe_fun, out_imm, out_rd, out_op2_sel, out_illegal, out_pc,
                         v_fun[i], v_imm[i], v_rd[i], v_op2[i], v_ill[i]);
            end
        end
        n_checks++; if (out_op1_sel !== 2'd0 || out_wb_sel !== 3'd0)
            begin n_fail++; $display("FAIL imm_ill_sels op1=%0d wb=%0d exp 0/0", out_op1_sel, out_wb_sel); end
        drive(1'b0, 32'h0, 32'h0);
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        drive(1'b1, 32'h0010_0093, 32'h0000_0200);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
        drive(1'b1, 32'h0020_0113, 32'h0000_0204);
        @(negedge clk);
        drive(1'b1, 32'h0030_0193, 32'h0000_0208);
        n_checks++; if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 32'h200)
            begin n_fail++; $display("FAIL bp_full ready=%b valid=%b pc=%h exp 0/1/200", in_ready, out_valid, out_pc); end
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0 || out_pc !== 32'h200 || out_rd !== 5'd1)
            begin n_fail++; $display("FAIL bp_hold ready=%b pc=%h rd=%0d exp 0/200/1", in_ready, out_pc, out_rd); end
        out_ready = 1'b1;
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h204 || out_imm !== 32'd2 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL bp_drain_b valid=%b pc=%h imm=%h ready=%b exp 1/204/2/1", out_valid, out_pc, out_imm, in_ready); end
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h208 || out_rd !== 5'd3)
            begin n_fail++; $display("FAIL bp_drain_c valid=%b pc=%h rd=%0d exp 1/208/3", out_valid, out_pc, out_rd); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty got=%b exp=0", out_valid); end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        drive(1'b1, 32'h0040_0213, 32'h0000_0300);
        @(negedge clk);
        drive(1'b1, 32'h0050_0293, 32'h0000_0304);
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL fl_full ready=%b exp=0", in_ready); end
        flush = 1'b1;
        drive(1'b1, 32'h0060_0313, 32'h0000_0308);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        n_checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1)
            begin n_fail++; $display("FAIL fl_after valid=%b ready=%b exp 0/1", out_valid, in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_no_emit%0d valid=%b pc=%h exp 0", i, out_valid, out_pc); end
        end
        drive(1'b1, 32'h0070_0393, 32'h0000_0310);
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b1 || out_pc !== 32'h310)
            begin n_fail++; $display("FAIL fl_one valid=%b pc=%h exp 1/310", out_valid, out_pc); end
        flush = 1'b1;
        drive(1'b1, 32'h0080_0413, 32'h0000_0314);
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_drop valid=%b pc=%h exp 0", out_valid, out_pc); end
        @(negedge clk);
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fl_drop2 valid=%b exp 0", out_valid); end
    endtask

    task automatic test_mul();
        out_ready = 1'b1;
        drive(1'b1, 32'h0273_02B3, 32'h0000_0500);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        n_checks++; if (out_rs1 !== 5'd6 || out_rs2 !== 5'd7)
            begin n_fail++; $display("FAIL mul_regs rs1=%0d rs2=%0d exp 6/7", out_rs1, out_rs2); end
`ifdef RV_M_EXT_EN
        n_checks++; if (out_exe_fun !== ALU_MUL || out_illegal !== 1'b0 || out_rd !== 5'd5 || out_wb_sel !== WB_ALU)
            begin n_fail++; $display("FAIL mul_dec fun=%0d ill=%b rd=%0d wb=%0d exp %0d/0/5/1", out_exe_fun, out_illegal, out_rd, out_wb_sel, ALU_MUL); end
`else
        n_checks++; if (out_illegal !== 1'b1 || out_exe_fun !== 5'd0 || out_rd !== 5'd0 || out_rf_wen !== 2'd0)
            begin n_fail++; $display("FAIL mul_ill ill=%b fun=%0d rd=%0d rf_wen=%0d exp 1/0/0/0", out_illegal, out_exe_fun, out_rd, out_rf_wen); end
`endif
        @(negedge clk);
    endtask

    task automatic test_rst_mid();
        out_ready = 1'b0;
        drive(1'b1, 32'h0010_0093, 32'h0000_0600);
        @(negedge clk);
        drive(1'b1, 32'h0020_0113, 32'h0000_0604);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0);
        n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0)
            begin n_fail++; $display("FAIL rm_full valid=%b ready=%b exp 1/0", out_valid, in_ready); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async valid=%b exp 0", out_valid); end
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_pc !== 32'h0)
            begin n_fail++; $display("FAIL rm_after ready=%b valid=%b pc=%h exp 1/0/0", in_ready, out_valid, out_pc); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_sub_illegal();
        test_imm_formats();
        test_back_to_back();
        test_flush();
        test_mul();
        test_rst_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
# decode_stage

Pipelined RV32I instruction decode stage with valid/ready handshakes on both sides and a two-entry output skid buffer. It sits between fetch and execute and replaces the purely combinational decoder. It emits the full control bundle, register indices, a sign-extended immediate and an illegal-instruction flag. The datapath width is parametrised, and multiply/divide decode can be compiled in.

## Interface
- XLEN, 32: width of pc and imm; legal values are 32 and 64.
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  synchronous flush (branch redirect); drops all buffered entries
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  stage can accept an instruction
- in_inst  in  32  instruction word
- in_pc  in  XLEN  instruction address
- out_valid  out  1  decoded entry available
- out_ready  in  1  execute accepts the entry
- out_pc  out  XLEN  passed-through pc
- out_exe_fun  out  5  ALU/branch function code (package enum)
- out_op1_sel  out  2  operand-1 source: X, RS1, PC, IMZ
- out_op2_sel  out  3  operand-2 source: X, RS2, IMI, IMS, IMJ, IMU
- out_mem_wen  out  2  memory write enable / kind
- out_rf_wen  out  2  register-file write enable / kind
- out_wb_sel  out  3  write-back source: X, ALU, MEM, PC, CSR
- out_rs1, out_rs2, out_rd  out  5 each  register indices
- out_imm  out  XLEN  sign-extended immediate, selected by format
- out_illegal  out  1  unsupported encoding

## Operation
- Decoding is combinational in a sub-module. The result is captured together with in_pc into a 2-entry FIFO (skid buffer) on each accepted transfer.
- Transfers:
  - Accept occurs when in_valid && in_ready.
  - Emit occurs when out_valid && out_ready.
- FSM states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- FSM transitions:
  - Accept without emit: EMPTY→ONE, ONE→FULL.
  - Emit without accept: FULL→ONE, ONE→EMPTY.
  - Accept and emit together: stays in ONE. The head is replaced by the next entry, so there is no bubble.
- in_ready is a registered function of state only. It never depends on out_ready combinationally.
- Outputs always present the head entry. Order is strictly FIFO.
- Illegal encodings: any opcode/funct3/funct7 combination outside the decoded set produces:
  - exe_fun=ALU_X, all selects X, mem_wen=0, rf_wen=0;
  - illegal=1.
  - The entry still flows through the buffer in order.
- Immediate formats:
  - I: sign-extend inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'b0}, sign-extended to XLEN.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - All are sign-extended to XLEN.
- Shift-immediate decode: SLLI/SRLI/SRAI require inst[31:25] to be 0000000 or 0100000 as appropriate. Any other value is illegal.
- rd is forced to 0 when rf_wen=0, i.e. for branches, stores and illegal encodings.

## Timing
- Latency is 1 cycle: an instruction accepted in cycle N is visible on out_* in cycle N+1.
- Throughput is 1 instruction per cycle with out_ready held high.
- Reset values: state=EMPTY, in_ready=1, out_valid=0. All out_* data are 0, except out_exe_fun=ALU_X and out_illegal=0.
- Reset asserted mid-operation discards all entries immediately (asynchronously).
- flush: the next state is EMPTY regardless of in_valid or out_ready. An instruction offered in the flush cycle is dropped. Emit in the flush cycle still counts for the downstream stage.
- Data registers load only on accept. They hold their value when out_ready=0.

## Configuration
- RV_M_EXT_EN defined: OP opcode with funct7=0000001 decodes to MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU. Each uses its own exe_fun code, op1=RS1, op2=RS2, wb_sel=ALU, rf_wen=1.
- RV_M_EXT_EN undefined: those encodings are illegal. The exe_fun codes remain reserved in the package.

## Structure
- Package rv_pkg holds:
  - opcode constants: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OPIMM, OP;
  - the exe_fun enum, including M-extension codes;
  - the op1/op2/wb_sel/mem_wen/rf_wen encodings;
  - the decoded-bundle struct.
- Sub-module decode_core: purely combinational, maps inst to the bundle plus illegal. decode_stage instantiates it and owns the FIFO and FSM.

## Test plan
- Reset then ADDI x1,x0,5 (0x00500093) accepted with out_ready=1:
  - next cycle: out_valid=1, exe_fun=ADD, op1=RS1, op2=IMI, imm=5, rd=1, rf_wen=1, wb_sel=ALU.
- SUB x3,x1,x2 (0x402081B3), then 0xFFFFFFFF:
  - SUB: exe_fun=SUB, rs1=1, rs2=2, rd=3.
  - 0xFFFFFFFF: illegal=1, rf_wen=0, rd=0, in order.
- Back-pressure: out_ready=0 while offering 3 instructions:
  - 2 are accepted, then in_ready=0;
  - releasing out_ready drains all 3 in order with no bubble.
- flush asserted in state FULL while in_valid=1:
  - next cycle: out_valid=0, in_ready=1;
  - the offered instruction is never emitted.
- MUL x5,x6,x7 (0x027302B3):
  - with RV_M_EXT_EN: exe_fun=MUL, illegal=0;
  - without: illegal=1.
- rst pulsed while FULL, mid-cycle:
  - out_valid falls immediately;
  - in_ready=1 after release.
